// File: rtl/sram_bridge.sv
// Bridges the core's instruction and data ports onto one shared 16-bit async SRAM,
// two half-word accesses per word. Define SRAM_BRIDGE_IBUF_EN for a one-entry instruction buffer.
module sram_bridge #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iread_ce,
  input  logic [31:0]       irom_addr,
  output logic [31:0]       rom_inst,
  output logic              rfin_c,
  output logic              rfin_d,
  input  logic              dread_ce,
  input  logic              dwrite_ce,
  input  logic [31:0]       drom_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rom_rdata,
  output logic              rfin_a,
  output logic              rfin_b,
  output logic              wfin_a,
  output logic              wfin_b,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_din,
  output logic [15:0]       sram_dout,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] K_INST = 2'd0;
  localparam logic [1:0] K_DRD  = 2'd1;
  localparam logic [1:0] K_DWR  = 2'd2;

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam int unsigned WA_W = ADDR_W - 1;

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        kind, kind_nx;
  logic [WA_W-1:0]   waddr, waddr_nx;
  logic [15:0]       wdata_hi, wdata_hi_nx;
  logic [15:0]       lo_data, lo_data_nx;
  logic [31:0]       rom_inst_nx, rom_rdata_nx;
  logic              rfin_a_nx, rfin_b_nx, rfin_c_nx, rfin_d_nx, wfin_a_nx, wfin_b_nx;
  logic [ADDR_W-1:0] sram_addr_nx;
  logic [15:0]       sram_dout_nx;
  logic              sram_dq_oe_nx, sram_ce_n_nx, sram_oe_n_nx, sram_we_n_nx;
  logic              start_c;
  logic              is_wr_c;

`ifdef SRAM_BRIDGE_IBUF_EN
  logic              ibuf_valid, ibuf_valid_nx;
  logic [WA_W-1:0]   ibuf_tag, ibuf_tag_nx;
  logic [31:0]       ibuf_word, ibuf_word_nx;
`endif

  // Byte-address bits outside the SRAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{irom_addr[31:ADDR_W+1], irom_addr[1:0],
                              drom_addr[31:ADDR_W+1], drom_addr[1:0]};

  assign is_wr_c = (kind == K_DWR);

  // Next-state and registered-output logic
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    kind_nx       = kind;
    waddr_nx      = waddr;
    wdata_hi_nx   = wdata_hi;
    lo_data_nx    = lo_data;
    rom_inst_nx   = rom_inst;
    rom_rdata_nx  = rom_rdata;
    rfin_a_nx     = 1'b0;
    rfin_b_nx     = 1'b0;
    rfin_c_nx     = 1'b0;
    rfin_d_nx     = 1'b0;
    wfin_a_nx     = 1'b0;
    wfin_b_nx     = 1'b0;
    sram_addr_nx  = sram_addr;
    sram_dout_nx  = sram_dout;
    sram_dq_oe_nx = 1'b0;
    sram_ce_n_nx  = 1'b1;
    sram_oe_n_nx  = 1'b1;
    sram_we_n_nx  = 1'b1;
    start_c       = 1'b0;
`ifdef SRAM_BRIDGE_IBUF_EN
    ibuf_valid_nx = ibuf_valid;
    ibuf_tag_nx   = ibuf_tag;
    ibuf_word_nx  = ibuf_word;
`endif

    case (state)
      S_IDLE: begin
        if (dwrite_ce) begin
          kind_nx      = K_DWR;
          waddr_nx     = drom_addr[ADDR_W:2];
          wdata_hi_nx  = wdata[31:16];
          sram_dout_nx = wdata[15:0];
          start_c      = 1'b1;
        end else if (dread_ce) begin
          kind_nx  = K_DRD;
          waddr_nx = drom_addr[ADDR_W:2];
          start_c  = 1'b1;
        end else if (iread_ce) begin
          kind_nx  = K_INST;
          waddr_nx = irom_addr[ADDR_W:2];
`ifdef SRAM_BRIDGE_IBUF_EN
          if (ibuf_valid && (irom_addr[ADDR_W:2] == ibuf_tag)) begin
            state_nx    = S_DONE;
            rfin_c_nx   = 1'b1;
            rfin_d_nx   = 1'b1;
            rom_inst_nx = ibuf_word;
          end else begin
            start_c = 1'b1;
          end
`else
          start_c = 1'b1;
`endif
        end
        if (start_c) begin
          state_nx      = S_LO;
          cnt_nx        = '0;
          sram_ce_n_nx  = 1'b0;
          sram_oe_n_nx  = dwrite_ce;
          sram_we_n_nx  = !dwrite_ce;
          sram_dq_oe_nx = dwrite_ce;
          sram_addr_nx  = {waddr_nx, 1'b0};
        end
      end
      S_LO: begin
        sram_ce_n_nx  = 1'b0;
        sram_oe_n_nx  = is_wr_c;
        sram_we_n_nx  = !is_wr_c;
        sram_dq_oe_nx = is_wr_c;
        if (cnt == CNT_LAST) begin
          lo_data_nx   = sram_din;
          state_nx     = S_HI;
          cnt_nx       = '0;
          sram_addr_nx = {waddr, 1'b1};
          if (is_wr_c) sram_dout_nx = wdata_hi;
          rfin_a_nx    = (kind == K_DRD);
          rfin_c_nx    = (kind == K_INST);
          wfin_a_nx    = is_wr_c;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_HI: begin
        sram_ce_n_nx  = 1'b0;
        sram_oe_n_nx  = is_wr_c;
        sram_we_n_nx  = !is_wr_c;
        sram_dq_oe_nx = is_wr_c;
        if (cnt == CNT_LAST) begin
          state_nx      = S_DONE;
          sram_ce_n_nx  = 1'b1;
          sram_oe_n_nx  = 1'b1;
          sram_we_n_nx  = 1'b1;
          sram_dq_oe_nx = 1'b0;
          case (kind)
            K_DRD: begin
              rfin_b_nx    = 1'b1;
              rom_rdata_nx = {sram_din, lo_data};
            end
            K_INST: begin
              rfin_d_nx   = 1'b1;
              rom_inst_nx = {sram_din, lo_data};
`ifdef SRAM_BRIDGE_IBUF_EN
              ibuf_valid_nx = 1'b1;
              ibuf_tag_nx   = waddr;
              ibuf_word_nx  = {sram_din, lo_data};
`endif
            end
            default: wfin_b_nx = 1'b1;
          endcase
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
`ifdef SRAM_BRIDGE_IBUF_EN
        if (is_wr_c && (waddr == ibuf_tag)) ibuf_valid_nx = 1'b0;
`endif
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kind       <= K_INST;
      waddr      <= '0;
      wdata_hi   <= '0;
      lo_data    <= '0;
      rom_inst   <= '0;
      rom_rdata  <= '0;
      rfin_a     <= 1'b0;
      rfin_b     <= 1'b0;
      rfin_c     <= 1'b0;
      rfin_d     <= 1'b0;
      wfin_a     <= 1'b0;
      wfin_b     <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
`ifdef SRAM_BRIDGE_IBUF_EN
      ibuf_valid <= 1'b0;
      ibuf_tag   <= '0;
      ibuf_word  <= '0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      kind       <= kind_nx;
      waddr      <= waddr_nx;
      wdata_hi   <= wdata_hi_nx;
      lo_data    <= lo_data_nx;
      rom_inst   <= rom_inst_nx;
      rom_rdata  <= rom_rdata_nx;
      rfin_a     <= rfin_a_nx;
      rfin_b     <= rfin_b_nx;
      rfin_c     <= rfin_c_nx;
      rfin_d     <= rfin_d_nx;
      wfin_a     <= wfin_a_nx;
      wfin_b     <= wfin_b_nx;
      sram_addr  <= sram_addr_nx;
      sram_dout  <= sram_dout_nx;
      sram_dq_oe <= sram_dq_oe_nx;
      sram_ce_n  <= sram_ce_n_nx;
      sram_oe_n  <= sram_oe_n_nx;
      sram_we_n  <= sram_we_n_nx;
`ifdef SRAM_BRIDGE_IBUF_EN
      ibuf_valid <= ibuf_valid_nx;
      ibuf_tag   <= ibuf_tag_nx;
      ibuf_word  <= ibuf_word_nx;
`endif
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge: stimulus queues expected strobes and bus cycles, monitors compare.
module tb_sram_bridge;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        iread_ce, dread_ce, dwrite_ce;
  logic [31:0] irom_addr, drom_addr, wdata, rom_inst, rom_rdata;
  logic        rfin_a, rfin_b, rfin_c, rfin_d, wfin_a, wfin_b;
  logic [19:0] sram_addr;
  logic [15:0] sram_din, sram_dout;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic        s1_iread, s1_dread, s1_dwrite;
  logic [31:0] s1_iaddr, s1_daddr, s1_wdata, s1_inst, s1_rdata;
  logic        s1_rfin_a, s1_rfin_b, s1_rfin_c, s1_rfin_d, s1_wfin_a, s1_wfin_b;
  logic [19:0] s1_addr;
  logic [15:0] s1_din, s1_dout;
  logic        s1_dq_oe, s1_ce_n, s1_oe_n, s1_we_n;

  sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .iread_ce(iread_ce), .irom_addr(irom_addr), .rom_inst(rom_inst),
    .rfin_c(rfin_c), .rfin_d(rfin_d),
    .dread_ce(dread_ce), .dwrite_ce(dwrite_ce), .drom_addr(drom_addr), .wdata(wdata),
    .rom_rdata(rom_rdata), .rfin_a(rfin_a), .rfin_b(rfin_b), .wfin_a(wfin_a), .wfin_b(wfin_b),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .iread_ce(s1_iread), .irom_addr(s1_iaddr), .rom_inst(s1_inst),
    .rfin_c(s1_rfin_c), .rfin_d(s1_rfin_d),
    .dread_ce(s1_dread), .dwrite_ce(s1_dwrite), .drom_addr(s1_daddr), .wdata(s1_wdata),
    .rom_rdata(s1_rdata), .rfin_a(s1_rfin_a), .rfin_b(s1_rfin_b), .wfin_a(s1_wfin_a), .wfin_b(s1_wfin_b),
    .sram_addr(s1_addr), .sram_din(s1_din), .sram_dout(s1_dout), .sram_dq_oe(s1_dq_oe),
    .sram_ce_n(s1_ce_n), .sram_oe_n(s1_oe_n), .sram_we_n(s1_we_n)
  );

  // SRAM models: preloaded while reset is low, written when the bridge drives a write.
  logic [15:0] mem  [0:1023];
  logic [15:0] mem1 [0:15];
  assign sram_din = mem[sram_addr[9:0]];
  assign s1_din   = mem1[s1_addr[3:0]];

  always @(posedge clk) begin
    if (!rst) begin
      mem[10'h010] <= 16'h5678; mem[10'h011] <= 16'hABCD;
      mem[10'h030] <= 16'h1111; mem[10'h031] <= 16'h2222;
      mem[10'h080] <= 16'h3333; mem[10'h081] <= 16'h4444;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr[9:0]] <= sram_dout;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      mem1[4'h0] <= 16'h5678; mem1[4'h1] <= 16'hABCD;
      mem1[4'h2] <= 16'h0001; mem1[4'h3] <= 16'h0002;
    end
  end

  typedef struct { int code; int c; logic [31:0] d; } ev_t;
  typedef struct {
    int c; logic ce_n; logic oe_n; logic we_n; logic dq;
    logic [19:0] a; logic [15:0] dout; bit chk_a; bit chk_d;
  } bus_t;

  ev_t  evq[$];
  ev_t  ev1q[$];
  bus_t busq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_ev(input int code, input int c, input logic [31:0] d);
    ev_t e;
    e.code = code; e.c = c; e.d = d;
    evq.push_back(e);
  endtask

  task automatic push_bus(input int c, input logic ce_n, input logic oe_n, input logic we_n,
                          input logic dq, input logic [19:0] a, input logic [15:0] dout,
                          input bit chk_a, input bit chk_d);
    bus_t b;
    b.c = c; b.ce_n = ce_n; b.oe_n = oe_n; b.we_n = we_n; b.dq = dq;
    b.a = a; b.dout = dout; b.chk_a = chk_a; b.chk_d = chk_d;
    busq.push_back(b);
  endtask

  // Expected bus for cycles c0+1 .. c0+n of one access (LO, HI, then DONE).
  task automatic push_phases(input int c0, input bit wr, input logic [19:0] ha,
                             input logic [31:0] wd, input int n);
    for (int k = 1; k <= n; k++) begin
      if (k <= 2*W)
        push_bus(c0 + k, 1'b0, wr, !wr, wr, (k <= W) ? ha : (ha | 20'd1),
                 (k <= W) ? wd[15:0] : wd[31:16], 1'b1, wr);
      else
        push_bus(c0 + k, 1'b1, 1'b1, 1'b1, 1'b0, ha | 20'd1, wd[31:16], 1'b1, wr);
    end
  endtask

  // kind: 0 instruction fetch, 1 data read, 2 data write
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp);
    int c0;
    logic [19:0] ha;
    c0 = cyc;
    ha = addr[20:1];
    ha[0] = 1'b0;
    case (kind)
      0: begin iread_ce = 1'b1; irom_addr = addr; end
      1: begin dread_ce = 1'b1; drom_addr = addr; end
      default: begin dwrite_ce = 1'b1; drom_addr = addr; wdata = wd; end
    endcase
    push_phases(c0, kind == 2, ha, wd, 2*W + 1);
    case (kind)
      0: begin push_ev(2, c0 + W + 1, 0); push_ev(3, c0 + 2*W + 1, exp); end
      1: begin push_ev(0, c0 + W + 1, 0); push_ev(1, c0 + 2*W + 1, exp); end
      default: begin push_ev(4, c0 + W + 1, 0); push_ev(5, c0 + 2*W + 1, 0); end
    endcase
    repeat (2*W + 1) @(negedge clk);
    iread_ce = 1'b0; dread_ce = 1'b0; dwrite_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
    int c0;
    c0 = cyc;
    iread_ce = 1'b1; irom_addr = addr;
    push_ev(2, c0 + 1, 0);
    push_ev(3, c0 + 1, exp);
    push_bus(c0 + 1, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0);
    push_bus(c0 + 2, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    iread_ce = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every strobe pops the next expected event; listed bus cycles are compared.
  always @(negedge clk) begin
    logic [5:0] stb;
    ev_t  e;
    bus_t b;
    if (mon_en) begin
      stb = {wfin_b, wfin_a, rfin_d, rfin_c, rfin_b, rfin_a};
      for (int s = 0; s < 6; s++) begin
        if (stb[s]) begin
          checks++;
          if (evq.size() == 0) begin
            errors++;
            $display("FAIL strobe: unexpected strobe %0d at cycle %0d", s, cyc);
          end else begin
            e = evq.pop_front();
            if (e.code != s || e.c != cyc || (s == 1 && rom_rdata !== e.d) ||
                (s == 3 && rom_inst !== e.d)) begin
              errors++;
              $display("FAIL strobe: got id %0d cycle %0d rdata %h inst %h, required id %0d cycle %0d data %h",
                       s, cyc, rom_rdata, rom_inst, e.code, e.c, e.d);
            end
          end
        end
      end
      if (busq.size() > 0 && busq[0].c == cyc) begin
        b = busq.pop_front();
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== {b.ce_n, b.oe_n, b.we_n, b.dq} ||
            (b.chk_a && sram_addr !== b.a) || (b.chk_d && sram_dout !== b.dout)) begin
          errors++;
          $display("FAIL bus cycle %0d: got ce/oe/we/dq %b%b%b%b addr %h dout %h, required %b%b%b%b addr %h dout %h",
                   cyc, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_addr, sram_dout,
                   b.ce_n, b.oe_n, b.we_n, b.dq, b.a, b.dout);
        end
      end
    end
  end

  // Monitor for the single-wait-cycle instance.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && s1_rfin_b) begin
      checks++;
      if (ev1q.size() == 0) begin
        errors++;
        $display("FAIL w1_rfin_b: unexpected at cycle %0d", cyc);
      end else begin
        e = ev1q.pop_front();
        if (e.c != cyc || s1_rdata !== e.d) begin
          errors++;
          $display("FAIL w1_rfin_b: got cycle %0d data %h, required cycle %0d data %h",
                   cyc, s1_rdata, e.c, e.d);
        end
      end
    end
  end

  initial begin
    int   c0;
    ev_t  e;
    rst = 1'b0;
    iread_ce = 1'b0; dread_ce = 1'b0; dwrite_ce = 1'b0;
    irom_addr = '0; drom_addr = '0; wdata = '0;
    s1_iread = 1'b0; s1_dread = 1'b0; s1_dwrite = 1'b0;
    s1_iaddr = '0; s1_daddr = '0; s1_wdata = '0;
    repeat (3) @(negedge clk);

    chk("reset_strobes", 32'({wfin_b, wfin_a, rfin_d, rfin_c, rfin_b, rfin_a}), 32'd0);
    chk("reset_rom_inst", rom_inst, 32'd0);
    chk("reset_rom_rdata", rom_rdata, 32'd0);
    chk("reset_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'hE);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("reset_dout", 32'(sram_dout), 32'd0);

    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    access(1, 32'h20, 32'h0, 32'hABCD5678);
    access(2, 32'h40, 32'hDEADBEEF, 32'h0);
    chk("rdata_held_over_write", rom_rdata, 32'hABCD5678);
    chk("inst_held_over_write", rom_inst, 32'h0);
    access(1, 32'h40, 32'h0, 32'hDEADBEEF);

    // Simultaneous data read and instruction fetch: data wins, fetch takes the next slot.
    c0 = cyc;
    dread_ce = 1'b1; drom_addr = 32'h20;
    iread_ce = 1'b1; irom_addr = 32'h60;
    push_phases(c0, 1'b0, 20'h10, 32'h0, 2*W + 1);
    push_ev(0, c0 + W + 1, 0);
    push_ev(1, c0 + 2*W + 1, 32'hABCD5678);
    push_phases(c0 + 2*W + 2, 1'b0, 20'h30, 32'h0, 2*W + 1);
    push_ev(2, c0 + 2*W + 2 + W + 1, 0);
    push_ev(3, c0 + 4*W + 3, 32'h22221111);
    repeat (2*W + 1) @(negedge clk);
    dread_ce = 1'b0;
    repeat (2*W + 2) @(negedge clk);
    iread_ce = 1'b0;
    @(negedge clk);

    // Reset asserted in the first HI cycle abandons the read.
    c0 = cyc;
    dread_ce = 1'b1; drom_addr = 32'h20;
    push_phases(c0, 1'b0, 20'h10, 32'h0, W + 1);
    push_ev(0, c0 + W + 1, 0);
    push_bus(c0 + W + 2, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0, 16'd0, 1'b1, 1'b1);
    repeat (W + 1) @(negedge clk);
    rst = 1'b0;
    dread_ce = 1'b0;
    @(negedge clk);
    chk("midreset_rom_rdata", rom_rdata, 32'd0);
    chk("midreset_rom_inst", rom_inst, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    access(1, 32'h20, 32'h0, 32'hABCD5678);

    // Repeated fetch of 0x100, then a write to the same word before refetching.
    access(0, 32'h100, 32'h0, 32'h44443333);
`ifdef SRAM_BRIDGE_IBUF_EN
    fetch_hit(32'h100, 32'h44443333);
`else
    access(0, 32'h100, 32'h0, 32'h44443333);
`endif
    access(2, 32'h100, 32'h55556666, 32'h0);
    chk("inst_held_over_write2", rom_inst, 32'h44443333);
    access(0, 32'h100, 32'h0, 32'h55556666);

    // Single wait cycle: back-to-back reads complete four cycles apart.
    c0 = cyc;
    s1_dread = 1'b1; s1_daddr = 32'h20;
    e.code = 1; e.c = c0 + 3; e.d = 32'hABCD5678; ev1q.push_back(e);
    repeat (3) @(negedge clk);
    s1_daddr = 32'h24;
    e.code = 1; e.c = c0 + 7; e.d = 32'h00020001; ev1q.push_back(e);
    repeat (4) @(negedge clk);
    s1_dread = 1'b0;
    repeat (4) @(negedge clk);

    chk("strobes_left", 32'(evq.size()), 32'd0);
    chk("w1_strobes_left", 32'(ev1q.size()), 32'd0);
    chk("bus_left", 32'(busq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
